// File: rtl/matmul4x4_seq_if.sv
// Host/datapath bundle for matmul4x4_seq: byte stream in, result stream out, operand/result buses.
// slave is the sequencer side; master is the host/DMA plus datapath side.
interface matmul4x4_seq_if;
    logic         start;
    logic         acc_clr;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic [127:0] a_flat;
    logic [127:0] b_flat;
    logic [255:0] c_flat;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  out_data;
    logic         out_last;
    logic         busy;
    logic         done;

    modport slave (
        input  start, acc_clr, in_valid, in_data, c_flat, out_ready,
        output in_ready, a_flat, b_flat, out_valid, out_data, out_last, busy, done
    );

    modport master (
        output start, acc_clr, in_valid, in_data, c_flat, out_ready,
        input  in_ready, a_flat, b_flat, out_valid, out_data, out_last, busy, done
    );
endinterface

// File: rtl/matmul4x4_seq.sv
// Sequencer for a 4x4 int8 matmul datapath; MATMUL_ACC_EN makes capture accumulate (C += A*B).
// Latency: 32 input beats + MM_LATENCY settle cycles + 16 output beats, done one cycle later.
// Backpressure: in_valid gaps and out_ready low both stall idx; nothing is dropped.
module matmul4x4_seq #(
    parameter int MM_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    matmul4x4_seq_if.slave   bus
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD_A = 3'd1;
    localparam logic [2:0] LOAD_B = 3'd2;
    localparam logic [2:0] WAIT   = 3'd3;
    localparam logic [2:0] DRAIN  = 3'd4;

    localparam logic [3:0] LAT_M1 = 4'(MM_LATENCY - 1);

    logic [2:0]   state;
    logic [3:0]   idx;
    logic [3:0]   wcnt;
    logic [127:0] a_reg;
    logic [127:0] b_reg;
    logic [255:0] res;
    logic         done_q;
    logic         in_xfer;
    logic         out_xfer;

    assign in_xfer  = bus.in_valid  & bus.in_ready;
    assign out_xfer = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            wcnt   <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            res    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
`ifdef MATMUL_ACC_EN
                    if (bus.acc_clr) res <= '0;
`endif
                    if (bus.start) begin
                        state <= LOAD_A;
                        idx   <= '0;
                    end
                end
                LOAD_A: begin
                    if (in_xfer) begin
                        a_reg[{idx, 3'b000} +: 8] <= bus.in_data;
                        idx <= idx + 4'd1;
                        if (idx == 4'd15) state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (in_xfer) begin
                        b_reg[{idx, 3'b000} +: 8] <= bus.in_data;
                        idx <= idx + 4'd1;
                        if (idx == 4'd15) begin
                            state <= WAIT;
                            wcnt  <= '0;
                        end
                    end
                end
                WAIT: begin
                    wcnt <= wcnt + 4'd1;
                    // Operands have been stable for MM_LATENCY cycles by this edge.
                    if (wcnt == LAT_M1) begin
`ifdef MATMUL_ACC_EN
                        for (int i = 0; i < 16; i++)
                            res[i*16 +: 16] <= res[i*16 +: 16] + bus.c_flat[i*16 +: 16];
`else
                        res <= bus.c_flat;
`endif
                        state <= DRAIN;
                        idx   <= '0;
                    end
                end
                DRAIN: begin
                    if (out_xfer) begin
                        idx <= idx + 4'd1;
                        if (idx == 4'd15) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef MATMUL_ACC_EN
    logic unused_acc_clr;
    assign unused_acc_clr = bus.acc_clr;
`endif

    assign bus.in_ready  = (state == LOAD_A) || (state == LOAD_B);
    assign bus.out_valid = (state == DRAIN);
    assign bus.out_data  = (state == DRAIN) ? res[{idx, 4'b0000} +: 16] : 16'h0000;
    assign bus.out_last  = (state == DRAIN) && (idx == 4'd15);
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
    assign bus.a_flat    = a_reg;
    assign bus.b_flat    = b_reg;

endmodule
